i2c_master_ctrl: RTL

- Transaction-level I2C master. Generates START, address+R/W byte, 0–15 data bytes (write or read), ACK/NACK handling and STOP on open-drain SCL/SDA.
- It is the initiator counterpart of the slave-side decode/receiver path. It produces exactly the START/STOP edges and the address byte that the slave decoder detects.
- Sits between a local command/stream interface and the pad-level open-drain drivers.

---
 rtl/i2c_pkg.sv | 28 ++
 rtl/i2c_scl_timer.sv | 55 +++++
 rtl/i2c_master_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master controller and its SCL quarter timer.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StAddr,
    StAddrAck,
    StWrByte,
    StWrAck,
    StRdByte,
    StRdAck,
    StStop
  } i2c_mst_state_t;

  // Quarter of a bit time: SCL low in Q0/Q1, high in Q2/Q3.
  typedef logic [1:0] quarter_t;

  localparam quarter_t Q0 = 2'd0;
  localparam quarter_t Q1 = 2'd1;
  localparam quarter_t Q2 = 2'd2;
  localparam quarter_t Q3 = 2'd3;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam int unsigned I2C_BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_scl_timer.sv
// Divides clk into SCL quarter periods of CLK_DIV cycles; hold freezes the count,
// restart clears the count within the current quarter.
module i2c_scl_timer
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     hold_i,
  input  logic     restart_i,
  output quarter_t quarter_o,
  output logic     qtr_start_o,
  output logic     qtr_end_o,
  output logic     mid_o
);

  localparam logic [7:0] CntMax = 8'(CLK_DIV - 1);
  localparam logic [7:0] CntMid = 8'(CLK_DIV / 2);

  logic [7:0] cnt_q, cnt_d;
  quarter_t   qtr_q, qtr_d;

  always_comb begin
    cnt_d     = cnt_q;
    qtr_d     = qtr_q;
    qtr_end_o = 1'b0;
    if (restart_i) begin
      cnt_d = '0;
    end else if (!hold_i) begin
      if (cnt_q == CntMax) begin
        cnt_d     = '0;
        qtr_d     = qtr_q + 2'd1;
        qtr_end_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      qtr_q <= Q0;
    end else begin
      cnt_q <= cnt_d;
      qtr_q <= qtr_d;
    end
  end

  assign quarter_o   = qtr_q;
  assign qtr_start_o = (cnt_q == '0);
  assign mid_o       = (cnt_q >= CntMid);

endmodule

// File: rtl/i2c_master_ctrl.sv
// Transaction-level I2C master: START, address byte, 0-15 data bytes, ACK/NACK, STOP.
// Define I2C_MASTER_CLK_STRETCH_EN to let a slave stretch the SCL high phase via scl_in.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [3:0] cmd_len,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       scl_out,
  output logic       sda_out,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       busy,
  output logic       done,
  output logic       nack_err
);

  localparam logic [2:0] LastBit = 3'(I2C_BITS_PER_BYTE - 1);

  i2c_mst_state_t state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] len_q, len_d;
  logic       rw_q, rw_d;
  logic       nack_q, nack_d;
  logic       samp_q, samp_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;

  quarter_t quarter;
  logic     qtr_start, qtr_end, mid;
  logic     hold, restart, wr_load, sample, bit_end;

  // First cycle of the first bit of a write byte: the byte must be present to proceed.
  assign wr_load = (state_q == StWrByte) && (bit_cnt_q == LastBit) && (quarter == Q0) &&
                   qtr_start;
  assign hold    = ((state_q == StIdle) && !cmd_valid) || (wr_load && !tx_valid);
  assign sample  = qtr_end && (quarter == Q2);
  assign bit_end = qtr_end && (quarter == Q3);

`ifdef I2C_MASTER_CLK_STRETCH_EN
  assign restart = (state_q != StIdle) && (quarter == Q2) && !scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign restart       = 1'b0;
`endif

  i2c_scl_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .hold_i     (hold),
    .restart_i  (restart),
    .quarter_o  (quarter),
    .qtr_start_o(qtr_start),
    .qtr_end_o  (qtr_end),
    .mid_o      (mid)
  );

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign tx_ready  = wr_load && tx_valid;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;

  // Pad drive: 1 releases the open-drain line.
  always_comb begin
    scl_out = 1'b1;
    sda_out = 1'b1;
    case (state_q)
      StStart: begin
        scl_out = (quarter != Q3);
        sda_out = !quarter[1];
      end
      StAddr: begin
        scl_out = quarter[1];
        sda_out = shreg_q[7];
      end
      StWrByte: begin
        scl_out = quarter[1];
        sda_out = wr_load ? 1'b1 : shreg_q[7];
      end
      StAddrAck, StWrAck, StRdByte: begin
        scl_out = quarter[1];
      end
      StRdAck: begin
        scl_out = quarter[1];
        sda_out = (len_q == 4'd1) ? I2C_NACK : I2C_ACK;
      end
      StStop: begin
        scl_out = quarter[1];
        sda_out = (quarter == Q3) && mid;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    len_d      = len_q;
    rw_d       = rw_q;
    nack_d     = nack_q;
    samp_d     = samp_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    done       = 1'b0;
    nack_err   = 1'b0;
    if (sample) samp_d = sda_in;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d   = StStart;
          shreg_d   = {cmd_addr, cmd_rw};
          rw_d      = cmd_rw;
          len_d     = cmd_len;
          nack_d    = 1'b0;
          bit_cnt_d = LastBit;
        end
      end
      StStart: begin
        if (bit_end) state_d = StAddr;
      end
      StAddr, StWrByte: begin
        if (tx_ready) shreg_d = tx_data;
        if (bit_end) begin
          shreg_d   = {shreg_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 3'd1;
          if (bit_cnt_q == '0) state_d = (state_q == StAddr) ? StAddrAck : StWrAck;
        end
      end
      StAddrAck: begin
        if (bit_end) begin
          bit_cnt_d = LastBit;
          if (samp_q == I2C_NACK) begin
            nack_d  = 1'b1;
            state_d = StStop;
          end else if (len_q == '0) begin
            state_d = StStop;
          end else begin
            state_d = rw_q ? StRdByte : StWrByte;
          end
        end
      end
      StWrAck: begin
        if (bit_end) begin
          bit_cnt_d = LastBit;
          if (samp_q == I2C_NACK) begin
            nack_d  = 1'b1;
            state_d = StStop;
          end else begin
            len_d   = len_q - 4'd1;
            state_d = (len_q == 4'd1) ? StStop : StWrByte;
          end
        end
      end
      StRdByte: begin
        if (sample) shreg_d = {shreg_q[6:0], sda_in};
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q - 3'd1;
          if (bit_cnt_q == '0) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
            state_d    = StRdAck;
          end
        end
      end
      StRdAck: begin
        if (bit_end) begin
          bit_cnt_d = LastBit;
          len_d     = len_q - 4'd1;
          state_d   = (len_q == 4'd1) ? StStop : StRdByte;
        end
      end
      StStop: begin
        if (bit_end) begin
          state_d  = StIdle;
          done     = 1'b1;
          nack_err = nack_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      bit_cnt_q  <= LastBit;
      len_q      <= '0;
      rw_q       <= 1'b0;
      nack_q     <= 1'b0;
      samp_q     <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      len_q      <= len_d;
      rw_q       <= rw_d;
      nack_q     <= nack_d;
      samp_q     <= samp_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

endmodule
